// File: rtl/uart_operand_receiver_pkg.sv
// Shared constants and FSM state encoding for the UART operand receiver.
package uart_operand_receiver_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;
  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock tick every DIV clocks, phase restartable by clear.
module uart_baud_tick #(
  parameter int DIV = 325
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  // Down-counter: tick on terminal count zero, so a clear yields a tick on the very next clock.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (cnt == '0) begin
      cnt <= W'(DIV - 1);
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/uart_operand_receiver.sv
// 8N1 UART receiver that tags each good byte with an alternating operand slot.
//
// state        | meaning
// ST_IDLE      | line idle, waiting for a low level
// ST_START     | counting to the start-bit midpoint, rejecting glitches
// ST_DATA      | sampling 8 data bits LSB first, one per 16 ticks
// ST_STOP      | sampling the stop bit
// ST_WAIT_IDLE | after a framing error, waiting for the line to go high
module uart_operand_receiver
  import uart_operand_receiver_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       uart_signal,
  output logic       uart_flag,
  output logic [7:0] uart_rx_data,
  output logic       frame_error
);

  localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);

  rx_state_t state, state_next;

  logic                 rx_meta, rx_sync;
  logic                 tick, tick_clear;
  logic [3:0]           tick_cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 bit_sample, frame_ok, frame_bad;
  logic                 at_mid, at_full;

  uart_baud_tick #(.DIV(DIV)) u_baud_tick (
    .clk   (clk),
    .reset (reset),
    .clear (tick_clear),
    .tick  (tick)
  );

  assign at_mid  = tick && (tick_cnt == 4'(MID_SAMPLE));
  assign at_full = tick && (tick_cnt == 4'(OVERSAMPLE - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    tick_clear = 1'b0;
    bit_sample = 1'b0;
    frame_ok   = 1'b0;
    frame_bad  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rx_sync) begin
          state_next = ST_START;
          tick_clear = 1'b1;
        end
      end
      ST_START: begin
        if (at_mid) state_next = rx_sync ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (at_full) begin
          bit_sample = 1'b1;
          if (bit_cnt == 3'(DATA_BITS - 1)) state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (at_full) begin
          if (rx_sync) begin
            frame_ok   = 1'b1;
            state_next = ST_IDLE;
          end else begin
            frame_bad  = 1'b1;
            state_next = ST_WAIT_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (rx_sync) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta      <= 1'b1;
      rx_sync      <= 1'b1;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      uart_signal  <= 1'b0;
      frame_error  <= 1'b0;
      uart_flag    <= 1'b0;
      uart_rx_data <= '0;
    end else begin
      rx_meta     <= rx;
      rx_sync     <= rx_meta;
      uart_signal <= frame_ok;
      frame_error <= frame_bad;

      // Every state change restarts the per-bit tick count.
      if (state_next != state) tick_cnt <= '0;
      else if (tick)           tick_cnt <= tick_cnt + 4'd1;

      if (state == ST_IDLE)  bit_cnt <= '0;
      else if (bit_sample)   bit_cnt <= bit_cnt + 3'd1;

      if (bit_sample) shift <= {rx_sync, shift[DATA_BITS-1:1]};

      if (frame_ok)    uart_rx_data <= shift;
      // Slot stays stable through the pulse and advances right after it.
      if (uart_signal) uart_flag <= ~uart_flag;
    end
  end

endmodule

// File: tb/tb_uart_operand_receiver.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and random frames.
module tb_uart_operand_receiver;

  localparam int CLK_HZ   = 1_600_000;
  localparam int BAUD     = 10_000;
  localparam int BIT_CLKS = 160;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       uart_signal;
  logic       uart_flag;
  logic [7:0] uart_rx_data;
  logic       frame_error;

  always #5 clk = ~clk;

  uart_operand_receiver #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .uart_signal  (uart_signal),
    .uart_flag    (uart_flag),
    .uart_rx_data (uart_rx_data),
    .frame_error  (frame_error)
  );

  typedef struct {
    logic       err;
    logic [7:0] data;
    logic       flag;
  } ev_t;

  ev_t ev_log[$];
  int  both_cnt = 0;

  // Each cycle with a pulse logs one event, so a stretched pulse shows up as an extra event.
  always @(negedge clk) begin
    if (uart_signal && frame_error) both_cnt++;
    if (uart_signal)      ev_log.push_back('{1'b0, uart_rx_data, uart_flag});
    else if (frame_error) ev_log.push_back('{1'b1, uart_rx_data, uart_flag});
  end

  int total = 0;
  int bad   = 0;
  int rd_idx = 0;

  logic       m_slot = 1'b0;
  logic [7:0] m_data = 8'h00;

  typedef struct {
    logic       rst;
    logic [7:0] data;
    logic       stop;
    int         stop_clks;
    int         idle;
    logic       exp_err;
    logic [7:0] exp_data;
    logic       exp_flag;
    logic [7:0] hold_data;
    logic       hold_flag;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    rx    = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_slot = 1'b0;
    m_data = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int stop_clks);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx = stop_bit;
    repeat (stop_clks) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic expect_event(input string name, input logic err, input logic [7:0] d,
                              input logic flag);
    ev_t e;
    if (rd_idx >= ev_log.size()) begin
      check({name, "_present"}, 32'd0, 32'd1);
    end else begin
      e = ev_log[rd_idx];
      rd_idx++;
      check({name, "_kind"}, 32'(e.err), 32'(err));
      check({name, "_data"}, 32'(e.data), 32'(d));
      check({name, "_flag"}, 32'(e.flag), 32'(flag));
    end
  endtask

  task automatic expect_quiet(input string name);
    check({name, "_extra_events"}, 32'(ev_log.size() - rd_idx), 32'd0);
    rd_idx = ev_log.size();
  endtask

  // Reference model: good frames deliver the byte in the current slot then flip it;
  // bad frames report an error and leave byte and slot untouched.
  task automatic model_frame(input string name, input logic [7:0] d, input logic stop_bit);
    if (stop_bit) begin
      expect_event(name, 1'b0, d, m_slot);
      m_slot = ~m_slot;
      m_data = d;
    end else begin
      expect_event(name, 1'b1, m_data, m_slot);
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 8'h5A, 1'b1, 160, 20, 1'b0, 8'h5A, 1'b0, 8'h5A, 1'b1};
    vecs[1] = '{1'b1, 8'h12, 1'b1,  80,  0, 1'b0, 8'h12, 1'b0, 8'h12, 1'b1};
    vecs[2] = '{1'b0, 8'h34, 1'b1,  80, 20, 1'b0, 8'h34, 1'b1, 8'h34, 1'b0};
    vecs[3] = '{1'b1, 8'hA5, 1'b0, 160, 40, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{1'b0, 8'h0F, 1'b1, 160, 20, 1'b0, 8'h0F, 1'b0, 8'h0F, 1'b1};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_signal", 32'(uart_signal), 32'd0);
    check("rst_ferr",   32'(frame_error), 32'd0);
    check("rst_flag",   32'(uart_flag),   32'd0);
    check("rst_data",   32'(uart_rx_data), 32'h00);

    for (int v = 0; v < 5; v++) begin
      if (vecs[v].rst) apply_reset();
      send_frame(vecs[v].data, vecs[v].stop, vecs[v].stop_clks);
      repeat (vecs[v].idle) @(negedge clk);
      expect_event($sformatf("vec%0d", v), vecs[v].exp_err, vecs[v].exp_data, vecs[v].exp_flag);
      expect_quiet($sformatf("vec%0d", v));
      check($sformatf("vec%0d_hold_data", v), 32'(uart_rx_data), 32'(vecs[v].hold_data));
      check($sformatf("vec%0d_hold_flag", v), 32'(uart_flag), 32'(vecs[v].hold_flag));
    end
    m_slot = 1'b1;
    m_data = 8'h0F;

    // Short low glitch must be rejected as a false start.
    rx = 1'b0;
    repeat (60) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    expect_quiet("glitch");
    send_frame(8'hC3, 1'b1, 160);
    repeat (10) @(negedge clk);
    model_frame("after_glitch", 8'hC3, 1'b1);
    expect_quiet("after_glitch");

    // Reset during bit 4 of 0xFF aborts the frame.
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    rx = 1'b1;
    repeat (4 * BIT_CLKS + 80) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_slot = 1'b0;
    m_data = 8'h00;
    check("midrst_data", 32'(uart_rx_data), 32'h00);
    check("midrst_flag", 32'(uart_flag), 32'd0);
    repeat (4 * BIT_CLKS + 79) @(negedge clk);
    expect_quiet("midrst");
    send_frame(8'h81, 1'b1, 160);
    repeat (10) @(negedge clk);
    model_frame("after_midrst", 8'h81, 1'b1);
    expect_quiet("after_midrst");

    // Break: one framing error, then silence while the line stays low.
    rx = 1'b0;
    repeat (3000) @(negedge clk);
    model_frame("break", 8'h00, 1'b0);
    expect_quiet("break");
    rx = 1'b1;
    repeat (50) @(negedge clk);
    expect_quiet("break_release");

    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      logic       good;
      int         stop_clks;
      int         idle;
      d    = 8'($urandom);
      good = ($urandom_range(0, 4) != 0);
      stop_clks = (good && ($urandom_range(0, 1) == 1)) ? 80 : 160;
      idle = good ? int'($urandom_range(0, 30)) : int'($urandom_range(40, 80));
      send_frame(d, good, stop_clks);
      repeat (idle) @(negedge clk);
      model_frame($sformatf("rnd%0d", n), d, good);
      expect_quiet($sformatf("rnd%0d", n));
      check($sformatf("rnd%0d_hold_data", n), 32'(uart_rx_data), 32'(m_data));
    end

    repeat (50) @(negedge clk);
    check("both_pulses", 32'(both_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
